// File: rtl/fm_phase_nco.sv
// Sample-rate phase accumulator with tuning-word load and a modulator phase offset; feeds the sine ROM.
// Optional build macro NCO_PHASE_DITHER_EN adds LFSR dither below the output address before truncation.
module fm_phase_nco #(
    parameter int unsigned SAMPLE_DIV = 2268,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned MOD_W      = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [ACC_W-1:0]  ftw,
    input  logic              ftw_load,
    input  logic [MOD_W-1:0]  mod_in,
    input  logic [3:0]        mod_depth,
    output logic              sample_tick,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    output logic              sync
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);
    localparam int unsigned EXT_W = ACC_W - MOD_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SAMPLE_DIV - 2);
    localparam logic [3:0] DEPTH_MAX = 4'd8;

    logic [CNT_W-1:0]  r_cnt;
    logic              r_tick;
    logic [ACC_W-1:0]  r_ftw_pending;
    logic [ACC_W-1:0]  r_acc;
    logic              r_wrap;
    logic [MOD_W-1:0]  r_mod;
    logic              r_s1_valid;
    logic [ADDR_W-1:0] r_addr;
    logic              r_addr_valid;
    logic              r_sync;

    logic [ACC_W-1:0]  w_ftw_active;
    logic [ACC_W:0]    w_acc_sum;
    logic [3:0]        w_depth;
    logic [ACC_W-1:0]  w_offset;
    logic [ACC_W-1:0]  w_phase;
    logic [ADDR_W-1:0] w_addr;

    // The pending-to-active transfer coincides with the add, so a same-cycle load bypasses the pending register.
    assign w_ftw_active = ftw_load ? ftw : r_ftw_pending;
    assign w_acc_sum    = {1'b0, r_acc} + {1'b0, w_ftw_active};
    assign w_depth      = (mod_depth > DEPTH_MAX) ? DEPTH_MAX : mod_depth;
    assign w_offset     = {{EXT_W{r_mod[MOD_W-1]}}, r_mod} << w_depth;

`ifdef NCO_PHASE_DITHER_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_phase   = r_acc + w_offset + ACC_W'({r_lfsr, 4'b0000});

    // Dither sequence steps once per sample; it only touches the output phase, never acc.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else if (r_tick) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end
`else
    assign w_phase = r_acc + w_offset;
`endif

    assign w_addr = ADDR_W'(w_phase >> (ACC_W - ADDR_W));

    // Divider, accumulator (stage 1) and output phase (stage 2).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_tick        <= 1'b0;
            r_ftw_pending <= '0;
            r_acc         <= '0;
            r_wrap        <= 1'b0;
            r_mod         <= '0;
            r_s1_valid    <= 1'b0;
            r_addr        <= '0;
            r_addr_valid  <= 1'b0;
            r_sync        <= 1'b0;
        end else begin
            if (!enable || (r_cnt == CNT_LAST)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Registered so the pulse lines up with the cycle in which the count sits at its last value.
            r_tick <= enable && (r_cnt == CNT_PRE);

            if (ftw_load) begin
                r_ftw_pending <= ftw;
            end

            r_s1_valid <= r_tick;
            if (r_tick) begin
                r_acc  <= w_acc_sum[ACC_W-1:0];
                r_wrap <= w_acc_sum[ACC_W];
                r_mod  <= mod_in;
            end

            r_addr_valid <= r_s1_valid;
            r_sync       <= r_s1_valid && r_wrap;
            if (r_s1_valid) begin
                r_addr <= w_addr;
            end
        end
    end

    assign sample_tick = r_tick;
    assign addr        = r_addr;
    assign addr_valid  = r_addr_valid;
    assign sync        = r_sync;

endmodule

// File: tb/tb_fm_phase_nco.sv
// Scoreboard bench for fm_phase_nco: directed samples push expected addr/sync, a monitor pops on addr_valid.
module tb_fm_phase_nco;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] ftw;
    logic        ftw_load;
    logic [23:0] mod_in;
    logic [3:0]  mod_depth;
    logic        sample_tick;
    logic [11:0] addr;
    logic        addr_valid;
    logic        sync;

    typedef struct packed {
        logic [11:0] addr;
        logic        sync;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_tick_cyc = -100;
    bit   mon_on = 1'b0;

    fm_phase_nco #(
        .SAMPLE_DIV(DIV),
        .ACC_W(32),
        .ADDR_W(12),
        .MOD_W(24)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .ftw(ftw),
        .ftw_load(ftw_load),
        .mod_in(mod_in),
        .mod_depth(mod_depth),
        .sample_tick(sample_tick),
        .addr(addr),
        .addr_valid(addr_valid),
        .sync(sync)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [11:0] a, input logic s);
        exp_t e;
        e.addr = a;
        e.sync = s;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per addr_valid and checks the tick-to-valid latency.
    always @(negedge clk) begin
        if (mon_on) begin
            if (sample_tick) last_tick_cyc = cyc;
            chk("sync_without_valid", 32'(sync & ~addr_valid), 32'd0);
            if (addr_valid) begin
                chk("valid_latency", 32'(cyc - last_tick_cyc), 32'd2);
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(addr), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("addr", 32'(addr), 32'(e.addr));
                    chk("sync", 32'(sync), 32'(e.sync));
                end
            end
        end
    end

    task automatic wait_tick(output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!sample_tick && waited < 100);
        if (!sample_tick) chk("tick_timeout", 32'(waited), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_ftw(input logic [31:0] v);
        @(negedge clk);
        ftw      = v;
        ftw_load = 1'b1;
        @(negedge clk);
        ftw_load = 1'b0;
    endtask

    // Runs n samples from an idle divider, then stops and lets the pipeline drain.
    task automatic run_ticks(input int n);
        int w;
        enable = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_tick(w);
            if (i == 0) chk("tick_first", 32'(w), 32'd3);
            else        chk("tick_period", 32'(w), 32'(DIV));
        end
        enable = 1'b0;
        idle(3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        idle(3);
        rst_n = 1'b1;
    endtask

    logic [23:0] mv [8] = '{24'h400000, 24'h800000, 24'h800000, 24'h400000,
                            24'h0FFFFF, 24'h100000, 24'hFFFFFF, 24'h000000};
    logic [3:0]  dv [8] = '{4'd8, 4'd8, 4'd12, 4'd15, 4'd0, 4'd1, 4'd8, 4'd8};
    logic [11:0] av [8] = '{12'h400, 12'h800, 12'h800, 12'h400,
                            12'h000, 12'h002, 12'hFFF, 12'h000};

    initial begin
        #1ms;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        rst_n     = 1'b1;
        enable    = 1'b0;
        ftw       = '0;
        ftw_load  = 1'b0;
        mod_in    = '0;
        mod_depth = '0;

        // Reset with enable high and ftw_load toggling: nothing must be captured.
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b1;
        ftw    = 32'h0010_0000;
        for (int i = 0; i < 3; i++) begin
            ftw_load = ~ftw_load;
            @(negedge clk);
        end
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_addr_valid", 32'(addr_valid), 32'd0);
        chk("rst_sample_tick", 32'(sample_tick), 32'd0);
        chk("rst_sync", 32'(sync), 32'd0);
        mon_on   = 1'b1;
        rst_n    = 1'b1;
        ftw_load = 1'b0;
        push_exp(12'h000, 1'b0);
        push_exp(12'h000, 1'b0);
        wait_tick(w);
        chk("first_tick_after_reset", 32'(w), 32'd3);
        wait_tick(w);
        chk("second_tick_period", 32'(w), 32'(DIV));
        enable = 1'b0;
        idle(3);

        // Ramp through a full accumulator wrap.
        load_ftw(32'h0010_0000);
        for (int k = 1; k <= 4100; k++) push_exp(12'(k % 4096), k == 4096);
        run_ticks(4100);

        // Nyquist step.
        do_reset();
        load_ftw(32'h8000_0000);
        for (int k = 1; k <= 6; k++) push_exp((k % 2 == 1) ? 12'h800 : 12'h000, k % 2 == 0);
        run_ticks(6);

        // Modulation depth and sign with ftw = 0.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            mod_in    = mv[i];
            mod_depth = dv[i];
            push_exp(av[i], 1'b0);
            run_ticks(1);
        end
        // Offset is per-sample only: acc must not absorb it.
        mod_in    = 24'h400000;
        mod_depth = 4'd8;
        load_ftw(32'hC000_0000);
        push_exp(12'h000, 1'b0);
        push_exp(12'hC00, 1'b1);
        run_ticks(2);
        mod_in    = mv[7];
        mod_depth = dv[7];

        // Late load two cycles before a tick, then a load in the tick cycle.
        do_reset();
        load_ftw(32'h0010_0000);
        push_exp(12'h001, 1'b0);
        push_exp(12'h002, 1'b0);
        push_exp(12'h003, 1'b0);
        run_ticks(3);
        push_exp(12'h005, 1'b0);
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        ftw      = 32'h0020_0000;
        ftw_load = 1'b1;
        @(negedge clk);
        ftw_load = 1'b0;
        wait_tick(w);
        chk("late_load_tick_wait", 32'(w), 32'd1);
        enable = 1'b0;
        idle(3);
        push_exp(12'h007, 1'b0);
        run_ticks(1);
        push_exp(12'h00A, 1'b0);
        enable = 1'b1;
        wait_tick(w);
        chk("tick_cycle_load_wait", 32'(w), 32'd3);
        ftw      = 32'h0030_0000;
        ftw_load = 1'b1;
        enable   = 1'b0;
        @(negedge clk);
        ftw_load = 1'b0;
        idle(2);
        push_exp(12'h00D, 1'b0);
        run_ticks(1);

        // Enable dropped mid-count.
        do_reset();
        load_ftw(32'h0010_0000);
        push_exp(12'h001, 1'b0);
        enable = 1'b1;
        wait_tick(w);
        chk("en_first_tick", 32'(w), 32'd3);
        idle(2);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_no_tick", 32'(sample_tick), 32'd0);
            chk("hold_addr", 32'(addr), 32'h001);
        end
        enable = 1'b1;
        push_exp(12'h002, 1'b0);
        wait_tick(w);
        chk("tick_after_enable", 32'(w), 32'd3);
        enable = 1'b0;
        idle(3);

        // Reset in the cycle after a tick discards the in-flight sample.
        enable = 1'b1;
        wait_tick(w);
        chk("pre_reset_tick", 32'(w), 32'd3);
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk("midrst_addr_valid", 32'(addr_valid), 32'd0);
        chk("midrst_addr", 32'(addr), 32'd0);
        chk("midrst_sync", 32'(sync), 32'd0);
        rst_n = 1'b1;
        idle(4);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
